// File: rtl/pll_sup_pkg.sv
// Shared types and defaults for the PLL lock supervisor.
// Holds the FSM state encoding, default timing constants, the loss-counter
// width and a saturating increment helper for the loss counter.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } sup_state_t;

    // Defaults sized for a 50 MHz reference clock.
    localparam int DEF_RST_CYCLES    = 16;
    localparam int DEF_LOCK_TIMEOUT  = 50000;
    localparam int DEF_STABLE_CYCLES = 1024;
    localparam int DEF_MAX_RETRIES   = 3;
    localparam int DEF_CNT_W         = 16;

    // Width of the lock-loss event counter.
    localparam int LOSS_W = 8;

    // Increment that sticks at all-ones instead of wrapping to zero.
    function automatic logic [LOSS_W-1:0] loss_sat_inc(input logic [LOSS_W-1:0] val);
        logic [LOSS_W-1:0] res;
        if (val == {LOSS_W{1'b1}}) begin
            res = val;
        end else begin
            res = val + LOSS_W'(1);
        end
        return res;
    endfunction

endpackage

// File: rtl/pll_lock_supervisor_sync.sv
// Two-flop synchroniser for a single asynchronous level (reset value 0).
// Used to bring the PLL lock indication into the reference-clock domain.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Two-stage capture of the asynchronous input; both stages cleared on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor.
// Sequences PLL reset, waits for a synchronised lock, requires the lock to be
// continuously stable before releasing the downstream system reset, retries on
// lock timeout and latches a fault after too many timed-out attempts. Lock
// losses while running are counted (saturating) and trigger a re-sequence.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int RST_CYCLES    = DEF_RST_CYCLES,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int MAX_RETRIES   = DEF_MAX_RETRIES,
    parameter int CNT_W         = DEF_CNT_W,
    localparam int RW           = $clog2(MAX_RETRIES + 1)
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              pll_locked,
    input  logic              relock_req,
    output logic              pll_rst,
    output logic              sys_rst,
    output logic              ready,
    output logic              fault,
    output logic [RW-1:0]     retry_cnt,
    output logic [LOSS_W-1:0] loss_cnt
);

    // Terminal counts: the shared counter always starts at zero on entry to a
    // state, so each state compares against its parameter minus one.
    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RW-1:0]    RETRY_MAX   = RW'(MAX_RETRIES);

    logic              locked_s;
    sup_state_t        state_r;
    sup_state_t        state_nxt_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_nxt_s;
    logic [CNT_W-1:0]  cnt_inc_s;
    logic [RW-1:0]     retry_r;
    logic [RW-1:0]     retry_nxt_s;
    logic [RW-1:0]     retry_inc_s;
    logic [LOSS_W-1:0] loss_r;
    logic [LOSS_W-1:0] loss_nxt_s;
    logic              pll_rst_r;
    logic              sys_rst_r;
    logic              ready_r;
    logic              fault_r;
    logic              pll_rst_nxt_s;
    logic              sys_rst_nxt_s;
    logic              ready_nxt_s;
    logic              fault_nxt_s;

    sync_2ff u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked),
        .q   (locked_s)
    );

    assign cnt_inc_s   = cnt_r + CNT_W'(1);
    assign retry_inc_s = retry_r + RW'(1);

    // Next-state, counter, retry and loss-count decisions.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = {CNT_W{1'b0}};
        retry_nxt_s = retry_r;
        loss_nxt_s  = loss_r;

        case (state_r)
            PLL_RST: begin
                if (cnt_r == RST_LAST) begin
                    state_nxt_s = WAIT_LOCK;
                end else begin
                    cnt_nxt_s = cnt_inc_s;
                end
            end

            WAIT_LOCK: begin
                if (locked_s) begin
                    state_nxt_s = STABLE;
                end else if (cnt_r == LOCK_LAST) begin
                    retry_nxt_s = retry_inc_s;
                    if (retry_inc_s == RETRY_MAX) begin
                        state_nxt_s = FAULT;
                    end else begin
                        state_nxt_s = PLL_RST;
                    end
                end else begin
                    cnt_nxt_s = cnt_inc_s;
                end
            end

            STABLE: begin
                // A single unlocked cycle restarts the lock wait with a fresh
                // timeout; it is not charged as a retry.
                if (!locked_s) begin
                    state_nxt_s = WAIT_LOCK;
                end else if (cnt_r == STABLE_LAST) begin
                    state_nxt_s = RUN;
                    retry_nxt_s = {RW{1'b0}};
                end else begin
                    cnt_nxt_s = cnt_inc_s;
                end
            end

            RUN: begin
                // Loss of lock takes priority over a relock request so that a
                // coincident request still records the loss.
                if (!locked_s) begin
                    state_nxt_s = PLL_RST;
                    loss_nxt_s  = loss_sat_inc(loss_r);
                end else if (relock_req) begin
                    state_nxt_s = PLL_RST;
                end else begin
                    state_nxt_s = RUN;
                end
            end

            FAULT: begin
                if (relock_req) begin
                    state_nxt_s = PLL_RST;
                    retry_nxt_s = {RW{1'b0}};
                end else begin
                    state_nxt_s = FAULT;
                    retry_nxt_s = RETRY_MAX;
                end
            end

            default: begin
                // Unreachable encodings recover through a full PLL reset.
                state_nxt_s = PLL_RST;
                retry_nxt_s = {RW{1'b0}};
            end
        endcase
    end

    // Output decode from the next state so the registered outputs track state_r.
    always_comb begin
        pll_rst_nxt_s = 1'b1;
        sys_rst_nxt_s = 1'b1;
        ready_nxt_s   = 1'b0;
        fault_nxt_s   = 1'b0;
        case (state_nxt_s)
            PLL_RST: begin
                pll_rst_nxt_s = 1'b1;
            end
            WAIT_LOCK, STABLE: begin
                pll_rst_nxt_s = 1'b0;
            end
            RUN: begin
                pll_rst_nxt_s = 1'b0;
                sys_rst_nxt_s = 1'b0;
                ready_nxt_s   = 1'b1;
            end
            FAULT: begin
                pll_rst_nxt_s = 1'b1;
                fault_nxt_s   = 1'b1;
            end
            default: begin
                pll_rst_nxt_s = 1'b1;
            end
        endcase
    end

    // State, counters and registered outputs; reset starts a fresh PLL reset.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_r   <= PLL_RST;
            cnt_r     <= {CNT_W{1'b0}};
            retry_r   <= {RW{1'b0}};
            loss_r    <= {LOSS_W{1'b0}};
            pll_rst_r <= 1'b1;
            sys_rst_r <= 1'b1;
            ready_r   <= 1'b0;
            fault_r   <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            retry_r   <= retry_nxt_s;
            loss_r    <= loss_nxt_s;
            pll_rst_r <= pll_rst_nxt_s;
            sys_rst_r <= sys_rst_nxt_s;
            ready_r   <= ready_nxt_s;
            fault_r   <= fault_nxt_s;
        end
    end

    assign pll_rst   = pll_rst_r;
    assign sys_rst   = sys_rst_r;
    assign ready     = ready_r;
    assign fault     = fault_r;
    assign retry_cnt = retry_r;
    assign loss_cnt  = loss_r;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor with short timing parameters.
// Cycle-exact vector table for start-up, glitch, timeout/fault and fault
// recovery; hand-written sequences for relock requests and repeated lock loss.
module tb_pll_lock_supervisor;

    localparam int RW = 2;

    logic         refclk = 1'b0;
    logic         rst;
    logic         pll_locked;
    logic         relock_req;
    logic         pll_rst;
    logic         sys_rst;
    logic         ready;
    logic         fault;
    logic [RW-1:0] retry_cnt;
    logic [7:0]   loss_cnt;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        r;
        logic        l;
        logic        q;
        logic [13:0] e;
    } vec_t;

    vec_t tbl[$];

    pll_lock_supervisor #(
        .RST_CYCLES    (4),
        .LOCK_TIMEOUT  (20),
        .STABLE_CYCLES (8),
        .MAX_RETRIES   (2),
        .CNT_W         (16)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .relock_req (relock_req),
        .pll_rst    (pll_rst),
        .sys_rst    (sys_rst),
        .ready      (ready),
        .fault      (fault),
        .retry_cnt  (retry_cnt),
        .loss_cnt   (loss_cnt)
    );

    always #5 refclk = ~refclk;

    function automatic logic [13:0] obs();
        return {pll_rst, sys_rst, ready, fault, retry_cnt, loss_cnt};
    endfunction

    function automatic void add(input int n, input logic r, input logic l, input logic q,
                                input logic pr, input logic sr, input logic rd, input logic fl,
                                input logic [1:0] rc, input logic [7:0] lc);
        vec_t v;
        v.r = r;
        v.l = l;
        v.q = q;
        v.e = {pr, sr, rd, fl, rc, lc};
        for (int k = 0; k < n; k++) tbl.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    // From a PLL_RST entry, wait (bounded) for ready and measure the pll_rst pulse.
    task automatic wait_ready(input string name);
        int pulse;
        bit got;
        pulse = pll_rst ? 1 : 0;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (pll_rst) pulse++;
            if (ready) begin
                got = 1'b1;
                break;
            end
        end
        check({name, "_ready"}, 32'(got), 32'd1);
        check({name, "_pulse"}, 32'(pulse), 32'd4);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_loss;
        rst = 1'b1;
        pll_locked = 1'b0;
        relock_req = 1'b0;

        // Fields: n, rst, lock, req | pll_rst, sys_rst, ready, fault, retry, loss
        // Start-up: lock rises 3 cycles after pll_rst falls, RUN 10 cycles later.
        add(1, 1,0,0, 1,1,0,0, 2'd0, 8'd0);
        add(3, 0,0,0, 1,1,0,0, 2'd0, 8'd0);
        add(3, 0,0,0, 0,1,0,0, 2'd0, 8'd0);
        add(5, 0,1,0, 0,1,0,0, 2'd0, 8'd0);
        add(1, 0,1,1, 0,1,0,0, 2'd0, 8'd0);   // request ignored in STABLE
        add(4, 0,1,0, 0,1,0,0, 2'd0, 8'd0);
        add(3, 0,1,0, 0,0,1,0, 2'd0, 8'd0);
        // One-cycle lock glitch seen at STABLE cnt=5: needs 8 fresh cycles.
        add(1, 1,0,0, 1,1,0,0, 2'd0, 8'd0);
        add(3, 0,1,0, 1,1,0,0, 2'd0, 8'd0);
        add(5, 0,1,0, 0,1,0,0, 2'd0, 8'd0);
        add(1, 0,0,0, 0,1,0,0, 2'd0, 8'd0);
        add(10, 0,1,0, 0,1,0,0, 2'd0, 8'd0);
        add(2, 0,1,0, 0,0,1,0, 2'd0, 8'd0);
        // No lock: two 20-cycle windows, then latched fault.
        add(1, 1,0,0, 1,1,0,0, 2'd0, 8'd0);
        add(3, 0,0,0, 1,1,0,0, 2'd0, 8'd0);
        add(6, 0,0,0, 0,1,0,0, 2'd0, 8'd0);
        add(1, 0,0,1, 0,1,0,0, 2'd0, 8'd0);   // request ignored in WAIT_LOCK
        add(13, 0,0,0, 0,1,0,0, 2'd0, 8'd0);
        add(1, 0,0,0, 1,1,0,0, 2'd1, 8'd0);
        add(1, 0,0,1, 1,1,0,0, 2'd1, 8'd0);   // request ignored in PLL_RST
        add(2, 0,0,0, 1,1,0,0, 2'd1, 8'd0);
        add(20, 0,0,0, 0,1,0,0, 2'd1, 8'd0);
        add(30, 0,0,0, 1,1,0,1, 2'd2, 8'd0);
        // Relock request clears the fault and starts a new sequence.
        add(1, 0,0,1, 1,1,0,0, 2'd0, 8'd0);
        add(3, 0,1,0, 1,1,0,0, 2'd0, 8'd0);
        add(9, 0,1,0, 0,1,0,0, 2'd0, 8'd0);
        add(3, 0,1,0, 0,0,1,0, 2'd0, 8'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            rst        = tbl[i].r;
            pll_locked = tbl[i].l;
            relock_req = tbl[i].q;
            tick();
            check($sformatf("vec%0d", i), 32'(obs()), 32'(tbl[i].e));
        end
        rst = 1'b0;
        relock_req = 1'b0;
        pll_locked = 1'b1;

        // Relock request in RUN: re-sequence without counting a loss.
        relock_req = 1'b1;
        tick();
        relock_req = 1'b0;
        check("t5_req", 32'(obs()), 32'({1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0}));
        wait_ready("t5_req");

        // Lock drop and relock request seen on the same cycle count as a loss.
        pll_locked = 1'b0;
        tick();
        tick();
        relock_req = 1'b1;
        tick();
        relock_req = 1'b0;
        check("t5_both", 32'(obs()), 32'({1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'd1}));
        pll_locked = 1'b1;
        wait_ready("t5_both");

        // Repeated lock loss in RUN; loss count saturates at 255.
        exp_loss = 1;
        for (int n = 0; n < 300; n++) begin
            pll_locked = 1'b0;
            tick();
            tick();
            tick();
            exp_loss = (exp_loss == 255) ? 255 : exp_loss + 1;
            check($sformatf("t3_loss%0d", n), 32'(obs()),
                  32'({1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'(exp_loss)}));
            pll_locked = 1'b1;
            wait_ready($sformatf("t3_relock%0d", n));
        end
        check("t3_sat", 32'(loss_cnt), 32'd255);

        // Reset clears the loss count; reset during STABLE re-asserts pll_rst.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_rst_clear", 32'(obs()), 32'({1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0}));
        for (int i = 0; i < 7; i++) tick();
        check("t6_in_stable", 32'(obs()), 32'({1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0}));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_rst_stable", 32'(obs()), 32'({1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0}));
        wait_ready("t6_after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
